// File: rtl/spi_slave_top.sv
// SPI responder with an 8-bit CPU register window: CTRL/STATUS, TXDATA, RXDATA.
// SPI pins are asynchronous to clk and are sampled through synchronizers.
// Frame timing (SPI mode, sample edge and shift edge) is taken from a copy of
// CPOL/CPHA captured when ss_n falls.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ss_n high or EN=0; miso held low, edges ignored
// S_ACTIVE | ss_n low with EN=1; bits shifted on synchronized sclk edges
module spi_slave_top #(
    parameter int         ADDR_LSB          = 0,
    parameter int         OPT_MEM_ADDR_BITS = 1,
    parameter logic [7:0] BASE_ADDR         = 8'h80
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic       ss_n
);

    localparam int DEC_LSB = ADDR_LSB + OPT_MEM_ADDR_BITS + 1;
    localparam logic [OPT_MEM_ADDR_BITS:0] IDX_CTRL = 0;
    localparam logic [OPT_MEM_ADDR_BITS:0] IDX_TX   = 1;
    localparam logic [OPT_MEM_ADDR_BITS:0] IDX_RX   = 2;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t     state_q;
    logic [2:0] sclk_q, ss_q;
    logic [1:0] mosi_q;
    logic       en_q, cpha_q, cpol_q;
    logic       cpha_a_q, cpol_a_q;
    logic [7:0] tx_q, rx_q, sr_q, rx_sr_q;
    logic       txe_q, rxv_q, ovr_q, skip_q;
    logic [2:0] cnt_q;

    logic                       hit, wr_hit, rd_hit;
    logic [OPT_MEM_ADDR_BITS:0] idx;
    logic                       wr_ctrl, wr_tx, rd_rx;
    logic [7:0]                 rd_data_d, load_d, rx_shift_d;
    logic                       sclk_lead, sclk_trail, sample_edge, shift_edge;
    logic                       ss_fall, ss_high;

    assign hit     = (addr[7:DEC_LSB] == BASE_ADDR[7:DEC_LSB]);
    assign idx     = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
    assign wr_hit  = wr_en && hit;
    assign rd_hit  = rd_en && hit;
    assign wr_ctrl = wr_hit && (idx == IDX_CTRL);
    assign wr_tx   = wr_hit && (idx == IDX_TX);
    assign rd_rx   = rd_hit && (idx == IDX_RX);

    // Edges are judged against the mode captured at frame start, not the live CTRL bits.
    assign sclk_lead   = (sclk_q[2] == cpol_a_q) && (sclk_q[1] != cpol_a_q);
    assign sclk_trail  = (sclk_q[2] != cpol_a_q) && (sclk_q[1] == cpol_a_q);
    assign sample_edge = cpha_a_q ? sclk_trail : sclk_lead;
    assign shift_edge  = cpha_a_q ? sclk_lead : sclk_trail;
    assign ss_fall     = ss_q[2] && !ss_q[1];
    assign ss_high     = ss_q[1];

    assign load_d     = txe_q ? 8'h00 : tx_q;
    assign rx_shift_d = {rx_sr_q[6:0], mosi_q[1]};
    assign miso       = (state_q == S_ACTIVE) ? sr_q[7] : 1'b0;

    // CPU read mux; reserved and unmapped indices read as zero.
    always_comb begin
        rd_data_d = 8'h00;
        case (idx)
            IDX_CTRL: rd_data_d = {rxv_q, txe_q, ovr_q, (state_q == S_ACTIVE),
                                   1'b0, cpol_q, cpha_q, en_q};
            IDX_TX:   rd_data_d = tx_q;
            IDX_RX:   rd_data_d = rx_q;
            default:  rd_data_d = 8'h00;
        endcase
    end

    // Two-stage synchronizers; the third sclk/ss_n stage is the previous value for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= 3'b000;
            ss_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ss_q   <= {ss_q[1:0], ss_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    // Register file and frame FSM. Later assignments win, so a TXDATA write
    // beats the TXE set from a load, and a new overrun beats an OVR clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            cpha_q   <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_a_q <= 1'b0;
            cpol_a_q <= 1'b0;
            tx_q     <= 8'h00;
            rx_q     <= 8'h00;
            sr_q     <= 8'h00;
            rx_sr_q  <= 8'h00;
            txe_q    <= 1'b1;
            rxv_q    <= 1'b0;
            ovr_q    <= 1'b0;
            skip_q   <= 1'b0;
            cnt_q    <= 3'd0;
            dout     <= 8'h00;
        end else begin
            if (wr_ctrl) begin
                en_q   <= din[0];
                cpha_q <= din[1];
                cpol_q <= din[2];
                if (din[5]) ovr_q <= 1'b0;
            end
            if (wr_tx) tx_q <= din;
            if (rd_hit) begin
                dout <= rd_data_d;
                if (rd_rx) rxv_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (ss_fall && en_q) begin
                        state_q  <= S_ACTIVE;
                        cpha_a_q <= cpha_q;
                        cpol_a_q <= cpol_q;
                        sr_q     <= load_d;
                        txe_q    <= 1'b1;
                        cnt_q    <= 3'd0;
                        skip_q   <= cpha_q;
                    end
                end
                S_ACTIVE: begin
                    if (ss_high || !en_q) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 3'd0;
                        skip_q  <= 1'b0;
                    end else if (sample_edge) begin
                        rx_sr_q <= rx_shift_d;
                        if (cnt_q == 3'd7) begin
                            rx_q   <= rx_shift_d;
                            rxv_q  <= 1'b1;
                            // A read of RXDATA in this same cycle already took the old byte.
                            if (rxv_q && !rd_rx) ovr_q <= 1'b1;
                            cnt_q  <= 3'd0;
                            sr_q   <= load_d;
                            txe_q  <= 1'b1;
                            skip_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end else if (shift_edge) begin
                        if (skip_q) skip_q <= 1'b0;
                        else        sr_q   <= {sr_q[6:0], 1'b0};
                    end
                end
            endcase

            if (wr_tx) txe_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_top.sv
// Bench for spi_slave_top: a behavioural SPI master plus a byte-level model
// of the register file, driven by directed cases and randomized frames.
module tb_spi_slave_top;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] addr, din, dout;
    logic       wr_en, rd_en, sclk, mosi, miso, ss_n;

    always #5 clk = ~clk;

    spi_slave_top dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
        .wr_en(wr_en), .rd_en(rd_en), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic       m_en, m_cpha, m_cpol, m_txe, m_rxv, m_ovr, m_busy;
    logic [7:0] m_tx, m_rx, m_dout;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    function automatic logic [7:0] m_status();
        return {m_rxv, m_txe, m_ovr, m_busy, 1'b0, m_cpol, m_cpha, m_en};
    endfunction

    task automatic model_reset();
        m_en = 0; m_cpha = 0; m_cpol = 0; m_txe = 1; m_rxv = 0; m_ovr = 0;
        m_busy = 0; m_tx = 0; m_rx = 0; m_dout = 0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; din = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        if (a[7:2] == 6'b100000) begin
            if (a[1:0] == 2'd0) begin
                m_en = d[0]; m_cpha = d[1]; m_cpol = d[2];
                if (d[5]) m_ovr = 1'b0;
            end else if (a[1:0] == 2'd1) begin
                m_tx = d; m_txe = 1'b0;
            end
        end
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a);
        logic [7:0] exp;
        logic       is_hit;
        is_hit = (a[7:2] == 6'b100000);
        if (!is_hit)             exp = m_dout;
        else if (a[1:0] == 2'd0) exp = m_status();
        else if (a[1:0] == 2'd1) exp = m_tx;
        else if (a[1:0] == 2'd2) exp = m_rx;
        else                     exp = 8'h00;
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check(tag, dout, exp);
        m_dout = exp;
        if (is_hit && a[1:0] == 2'd2) m_rxv = 1'b0;
    endtask

    // Master side of one byte (or its first nbits), MSB first, in the model's mode.
    task automatic spi_byte(input logic [7:0] tx_m, input int nbits, output logic [7:0] rx_m);
        rx_m = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!m_cpha) begin
                mosi = tx_m[i];
                wait_clk(HALF);
                sclk = ~m_cpol;
                rx_m[i] = miso;
                wait_clk(HALF);
                sclk = m_cpol;
            end else begin
                sclk = ~m_cpol;
                mosi = tx_m[i];
                wait_clk(HALF);
                sclk = m_cpol;
                rx_m[i] = miso;
                wait_clk(HALF);
            end
        end
    endtask

    // Full frame: nbytes complete bytes then an optional partial byte of tail bits.
    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int nbytes, input int tail);
        logic [7:0] mb [3];
        logic [7:0] rb, next_load;
        mb[0] = b0; mb[1] = b1; mb[2] = b2;
        sclk = m_cpol;
        wait_clk(8);
        ss_n = 1'b0;
        next_load = 8'h00;
        if (m_en) begin
            next_load = m_txe ? 8'h00 : m_tx;
            m_txe = 1'b1;
            m_busy = 1'b1;
        end
        wait_clk(8);
        read_chk("busy_status", 8'h80);
        for (int k = 0; k < nbytes; k++) begin
            spi_byte(mb[k], 8, rb);
            if (m_en) begin
                check("master_rx", rb, next_load);
                if (m_rxv) m_ovr = 1'b1;
                m_rx = mb[k];
                m_rxv = 1'b1;
                next_load = 8'h00;
            end else begin
                check("master_rx_dis", rb, 8'h00);
            end
        end
        if (tail > 0) spi_byte(8'($urandom), tail, rb);
        wait_clk(HALF);
        ss_n = 1'b1;
        m_busy = 1'b0;
        wait_clk(8);
        check("miso_idle", {7'd0, miso}, 8'h00);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] modes [3];
        modes[0] = 8'h03; modes[1] = 8'h05; modes[2] = 8'h07;

        reset_n = 1'b0; addr = 0; din = 0; wr_en = 0; rd_en = 0;
        sclk = 0; mosi = 0; ss_n = 1;
        model_reset();
        wait_clk(3);
        check("rst_dout", dout, 8'h00);
        check("rst_miso", {7'd0, miso}, 8'h00);
        reset_n = 1'b1;
        wait_clk(2);
        read_chk("rst_status", 8'h80);
        read_chk("rst_tx", 8'h81);
        read_chk("rst_rx", 8'h82);
        read_chk("rst_rsvd", 8'h83);

        // mode 0 single byte
        reg_write(8'h80, 8'h01);
        reg_write(8'h81, 8'hA5);
        read_chk("txe_cleared", 8'h80);
        run_frame(8'h3C, 8'h00, 8'h00, 1, 0);
        read_chk("rxv_set", 8'h80);
        read_chk("rx_3c", 8'h82);
        read_chk("rxv_clr", 8'h80);

        // modes 1..3
        for (int m = 0; m < 3; m++) begin
            reg_write(8'h80, modes[m]);
            reg_write(8'h81, 8'h81);
            run_frame(8'h7E, 8'h00, 8'h00, 1, 0);
            read_chk("mode_rx", 8'h82);
        end

        // two bytes, no refill, no RX read in between -> overrun
        reg_write(8'h80, 8'h01);
        reg_write(8'h81, 8'hC3);
        run_frame(8'h11, 8'h22, 8'h00, 2, 0);
        read_chk("ovr_status", 8'h80);
        read_chk("ovr_rx", 8'h82);
        reg_write(8'h80, 8'h21);
        read_chk("ovr_clear", 8'h80);

        // aborted frame after 4 bits, then a full frame
        reg_write(8'h81, 8'h55);
        run_frame(8'h00, 8'h00, 8'h00, 0, 4);
        read_chk("abort_status", 8'h80);
        run_frame(8'h96, 8'h00, 8'h00, 1, 0);
        read_chk("after_abort_rx", 8'h82);

        // no decode hit
        read_chk("pre_nohit", 8'h81);
        reg_write(8'h02, 8'hFF);
        read_chk("nohit_rd", 8'h02);
        read_chk("nohit_status", 8'h80);
        read_chk("nohit_tx", 8'h81);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            logic [7:0] c;
            c = {2'b00, ($urandom_range(0, 3) == 0), 2'b00, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) != 0)};
            reg_write(8'h80, c);
            if ($urandom_range(0, 1) == 1) reg_write(8'h81, 8'($urandom));
            run_frame(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
            if ($urandom_range(0, 1) == 1) read_chk("rnd_status", 8'h80);
            if ($urandom_range(0, 2) != 0) read_chk("rnd_rx", 8'h82);
            if ($urandom_range(0, 3) == 0) read_chk("rnd_tx", 8'h81);
        end

        // reset in the middle of a frame
        reg_write(8'h80, 8'h01);
        reg_write(8'h81, 8'hFF);
        read_chk("pre_rst_tx", 8'h81);
        sclk = 1'b0;
        wait_clk(8);
        ss_n = 1'b0;
        m_busy = 1'b1;
        wait_clk(8);
        spi_byte(8'hFF, 3, rb);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_miso", {7'd0, miso}, 8'h00);
        check("midrst_dout", dout, 8'h00);
        wait_clk(2);
        ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wait_clk(2);
        reset_n = 1'b1;
        model_reset();
        wait_clk(4);
        read_chk("midrst_status", 8'h80);
        read_chk("midrst_tx", 8'h81);
        read_chk("midrst_rx", 8'h82);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave_top.md
# spi_slave_top

SPI responder (slave) with the same 8-bit CPU register interface as the SPI master peripheral, so a TRSQ8 core can act as the target device on an external SPI bus. It samples externally driven sclk/mosi/ss_n through synchronizers, shifts bytes MSB-first in any of the four SPI modes, and exposes a single-entry TX buffer and RX buffer with status flags. It is also the bus model used opposite the master peripheral in loopback simulations.

## Interface
- ADDR_LSB, 0, lowest address bit used for register index
- OPT_MEM_ADDR_BITS, 1, register index width minus 1 (4 registers)
- BASE_ADDR, 8'h80, block decodes when addr[7:ADDR_LSB+OPT_MEM_ADDR_BITS+1] equals the same bits of BASE_ADDR
- clk  in  1  system clock (one clock domain)
- reset_n  in  1  asynchronous, active-low reset
- addr  in  8  CPU address
- din  in  8  CPU write data
- dout  out  8  CPU read data (registered)
- wr_en  in  1  CPU write strobe, one cycle
- rd_en  in  1  CPU read strobe, one cycle
- sclk  in  1  SPI clock from master (asynchronous)
- mosi  in  1  SPI data from master
- miso  out  1  SPI data to master
- ss_n  in  1  slave select, active low

## Operation
- Register index idx = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB]; accesses without decode hit are ignored.
- idx 0 CTRL/STATUS. Write: bit0 EN, bit1 CPHA, bit2 CPOL, bit5 write-1-clears OVR. Read: {RXV, TXE, OVR, BUSY, 1'b0, CPOL, CPHA, EN}.
- idx 1 TXDATA: write loads TX buffer, TXE<=0; read returns TX buffer.
- idx 2 RXDATA: read returns RX buffer, clears RXV.
- idx 3 reserved: reads 8'h00, writes ignored.
- sclk, mosi, ss_n each pass through 2-FF synchronizer; edges detected from a third registered copy.
- CPOL/CPHA are latched into the active mode at synchronized ss_n falling edge; changes mid-frame apply to the next frame.
- Leading edge = sclk leaving CPOL level; sample edge = leading if CPHA=0, else trailing; shift edge = the other.
- States: IDLE (ss_n high or EN=0), ACTIVE (ss_n low, EN=1). BUSY=1 in ACTIVE.
- IDLE->ACTIVE on ss_n fall: shift reg <= TX buffer if TXE=0 else 8'h00; TXE<=1; bit count <=0; skip <= CPHA.
- Sample edge: rx_sr <= {rx_sr[6:0], mosi}; count++. On 8th sample: RX buffer <= completed byte, RXV<=1, OVR<=1 if RXV was already 1 (old byte overwritten), count<=0, shift reg reloaded from TX buffer as above, skip<=1.
- Shift edge: if skip, clear skip; else shift reg <= shift reg << 1.
- miso = shift reg[7] in ACTIVE, 0 in IDLE.
- ACTIVE->IDLE on ss_n rise (or EN cleared): partial byte discarded, count<=0, RXV unchanged; byte already loaded from TX buffer is lost.

## Timing
- Reset: dout=0, miso=0, CTRL=0, TX/RX buffers=0, TXE=1, RXV=0, OVR=0, state IDLE.
- dout updated on the clk edge where rd_en and hit are high; holds otherwise. Read data valid 1 cycle after rd_en.
- Writes take effect on the clk edge where wr_en is high.
- Pin-to-internal latency: 3 clk cycles for any edge; miso changes 1 cycle after detected shift edge or load.
- RXV/RXDATA update 1 cycle after detected 8th sample edge.
- sclk high and low phases must each be >= 4 clk periods; ss_n fall to first sclk edge >= 4 clk.
- Simultaneous TXDATA write and shift-reg load: load takes old buffer value (or 8'h00 if TXE=1); new write stays, TXE=0.
- Simultaneous RXDATA read and byte completion: dout gets old byte, RXV stays 1, OVR not set.
- Simultaneous OVR clear and new overrun: OVR=1.

## Test plan
- Reset, write CTRL=8'h01 at 0x80, TXDATA=8'hA5 at 0x81; master mode 0 sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; read 0x82 gives 8'h3C; STATUS RXV=1 then 0 after read.
- Modes 1,2,3 (CTRL 8'h03, 8'h05, 8'h07), TX 8'h81, master sends 8'h7E -> master receives 8'h81, RX 8'h7E in each mode.
- Two-byte frame without TX refill: first byte TX 8'hC3, second miso 8'h00; TXE=1 after first load.
- Two bytes received without RXDATA read -> OVR=1, RXDATA holds second byte; write 8'h21 to CTRL -> OVR=0, EN stays 1.
- ss_n raised after 4 bits -> RXV remains 0, next full frame receives correct byte, miso 0 while ss_n high.
- Access at 0x02 (no decode hit) with wr_en/rd_en -> no register change, dout unchanged; reset_n pulsed mid-frame -> all outputs and flags return to reset values.
